// File: rtl/mem_indirect_sequencer.sv
// ---------------------------------------------------------------------------
// mem_indirect_sequencer
//
// Purpose:
//   Runs the multi-cycle access sequence of a memory-indirect instruction
//   (LWi, SWi, Add-to-memory) on a single-ported data memory while the
//   pipeline is frozen. busy holds the freeze; done (or err on an ack
//   timeout) tells the hazard logic it may release it.
//
//   LWi : read ptr = mem[base]; read mem[ptr]; result = that word, wb_en
//   SWi : read ptr = mem[base]; write mem[ptr] = operand; result = ptr
//   Add : read mem[base]; write mem[base] = word + operand; result = sum
//
// Ports:
//   clk        rising-edge clock
//   rest       asynchronous reset, active low
//   start      op request from the MEM stage, sampled only when idle
//   op_code    2=LWi, 1=SWi, 0=Add, 3=none
//   base_addr  effective address (rs+imm)
//   operand    rt value (store data for SWi, addend for Add)
//   busy       high while an op is in flight (pipeline freeze)
//   done       one-cycle pulse, op finished successfully
//   err        one-cycle pulse, op aborted on ack timeout
//   result     LWi word / Add sum / SWi pointer, held until next success
//   wb_en      one-cycle pulse with done for LWi (write result to rt)
//   mem_req    memory request, held until mem_ack
//   mem_we     1=write, 0=read, valid while mem_req
//   mem_addr   memory address, valid while mem_req
//   mem_wdata  write data, valid while mem_req && mem_we
//   mem_rdata  read data, valid when mem_ack is high on a read
//   mem_ack    access complete
// ---------------------------------------------------------------------------
module mem_indirect_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              wb_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {IDLE, RD_PTR, RD_DAT, WR, FIN} state_t;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SWI  = 2'd1;
  localparam logic [1:0] OP_LWI  = 2'd2;
  localparam logic [1:0] OP_NONE = 2'd3;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] operand_q;
  logic [DATA_W-1:0] hold_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] sum;

  // Add-to-memory sum; the carry out is deliberately dropped.
  always_comb begin
    sum = mem_rdata + operand_q;
  end

  // Sequencer. Every access state raises mem_req one cycle after entry, so
  // mem_req is always low for at least one cycle between accesses and the
  // address/we/wdata registers are already settled when it rises. The value
  // destined for result is kept in hold_q and only committed on success, so
  // an aborted op leaves result untouched.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state     <= IDLE;
      op_q      <= OP_NONE;
      operand_q <= '0;
      hold_q    <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_en     <= 1'b0;
      result    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start && op_code != OP_NONE) begin
            op_q      <= op_code;
            operand_q <= operand;
            mem_addr  <= base_addr;
            mem_we    <= 1'b0;
            busy      <= 1'b1;
            state     <= (op_code == OP_ADD) ? RD_DAT : RD_PTR;
          end
        end

        RD_PTR, RD_DAT, WR: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            wait_cnt <= '0;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            case (state)
              RD_PTR: begin
                hold_q   <= mem_rdata;
                mem_addr <= ADDR_W'(mem_rdata);
                if (op_q == OP_SWI) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= operand_q;
                  state     <= WR;
                end else begin
                  state <= RD_DAT;
                end
              end
              RD_DAT: begin
                if (op_q == OP_LWI) begin
                  result <= mem_rdata;
                  done   <= 1'b1;
                  wb_en  <= 1'b1;
                  state  <= FIN;
                end else begin
                  hold_q    <= sum;
                  mem_we    <= 1'b1;
                  mem_wdata <= sum;
                  state     <= WR;
                end
              end
              default: begin
                mem_we <= 1'b0;
                result <= hold_q;
                done   <= 1'b1;
                state  <= FIN;
              end
            endcase
          end else if (wait_cnt == CNT_LAST) begin
            // Memory never answered: give up and return to idle with err.
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_indirect_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_indirect_sequencer
//
// Purpose:
//   Self-checking bench for mem_indirect_sequencer. A small word memory with
//   a programmable wait-state count answers the DUT's requests. Expected op
//   completions and expected memory accesses are queued when an op is
//   started and compared when the DUT reports done/err.
//
// Latency is counted in clock cycles from the cycle start is driven to the
// cycle done/err is seen; a zero-wait op therefore reads 5.
// ---------------------------------------------------------------------------
module tb_mem_indirect_sequencer;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic        d;
    logic        e;
    logic        w;
    logic [31:0] r;
    int          lat;
  } comp_t;

  logic              clk       = 1'b0;
  logic              rest      = 1'b1;
  logic              start     = 1'b0;
  logic [1:0]        op_code   = 2'd3;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [DATA_W-1:0] operand   = '0;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic              wb_en;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Memory model state
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [7:0]  wait_cnt   = 8'd0;
  logic [7:0]  wait_cfg   = 8'd0;
  logic        ack_enable = 1'b1;
  logic        stray_ack  = 1'b0;
  logic        pl_en      = 1'b0;
  logic [7:0]  pl_addr    = 8'd0;
  logic [31:0] pl_data    = 32'd0;

  // Monitor state
  acc_t obs_log [64];
  int   obs_wr    = 0;
  int   stab_err  = 0;
  int   gap_err   = 0;
  int   both_cnt  = 0;
  logic prev_req  = 1'b0;
  logic prev_ack  = 1'b0;
  logic prev_we   = 1'b0;
  logic [31:0] prev_addr  = 32'd0;
  logic [31:0] prev_wdata = 32'd0;

  // Bench bookkeeping (initial block only)
  int    errors    = 0;
  int    checks    = 0;
  int    obs_rd    = 0;
  int    last_busy = 0;
  logic  last_req  = 1'b0;
  comp_t exp_q[$];
  acc_t  exp_acc[$];

  mem_indirect_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rest     (rest),
    .start    (start),
    .op_code  (op_code),
    .base_addr(base_addr),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .wb_en    (wb_en),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory answers after wait_cfg cycles of a held request; stray_ack lets
  // the bench raise ack with no request outstanding.
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack   = stray_ack | (mem_req && ack_enable && (wait_cnt == wait_cfg));

  // Memory storage, preload port and wait-state counter.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (!mem_req || mem_ack) wait_cnt <= 8'd0;
    else wait_cnt <= wait_cnt + 8'd1;
  end

  // Log every completed access for the scoreboard.
  always @(posedge clk) begin
    if (rest && mem_req && mem_ack && obs_wr < 64) begin
      obs_log[obs_wr] <= '{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : mem_rdata)};
      obs_wr <= obs_wr + 1;
    end
  end

  // Protocol watch: request fields stable while mem_req is held, a gap after
  // every ack, and done/err never together.
  always @(negedge clk) begin
    if (prev_req && mem_req &&
        (mem_addr !== prev_addr || mem_we !== prev_we || (mem_we && mem_wdata !== prev_wdata)))
      stab_err <= stab_err + 1;
    if (prev_req && prev_ack && mem_req) gap_err <= gap_err + 1;
    if (done && err) both_cnt <= both_cnt + 1;
    prev_req   <= mem_req;
    prev_ack   <= mem_ack;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic expect_op(input logic d, input logic e, input logic w, input logic [31:0] r, input int lat);
    exp_q.push_back('{d, e, w, r, lat});
  endtask

  task automatic expect_acc(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_acc.push_back('{we: we, addr: addr, data: data});
  endtask

  // Drives one start cycle; called at a negedge, returns one cycle later.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] base, input logic [31:0] opnd);
    start     = 1'b1;
    op_code   = op;
    base_addr = base;
    operand   = opnd;
    @(negedge clk);
    start   = 1'b0;
    op_code = 2'd3;
  endtask

  task automatic check_accesses();
    acc_t a;
    acc_t o;
    check_output("access count", 64'(obs_wr - obs_rd), 64'(exp_acc.size()));
    while (obs_rd < obs_wr && exp_acc.size() > 0) begin
      a = exp_acc.pop_front();
      o = obs_log[obs_rd];
      obs_rd++;
      check_output("access we", 64'(o.we), 64'(a.we));
      check_output("access addr", 64'(o.addr), 64'(a.addr));
      check_output("access data", 64'(o.data), 64'(a.data));
    end
    exp_acc.delete();
    obs_rd = obs_wr;
  endtask

  // Waits (bounded) for done/err, then pops and compares the expected
  // completion and the access log, then checks the block went idle.
  task automatic run_and_check(input int budget, input int lat0);
    comp_t e;
    int    lat;
    lat       = lat0;
    last_busy = busy ? 1 : 0;
    while (!(done || err) && lat < budget) begin
      @(negedge clk);
      lat++;
      if (busy) last_busy++;
    end
    last_req = mem_req;
    if (!(done || err)) begin
      check_output("completion wait", 64'd0, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_output("unexpected completion", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_output("done", 64'(done), 64'(e.d));
      check_output("err", 64'(err), 64'(e.e));
      check_output("wb_en", 64'(wb_en), 64'(e.w));
      check_output("result", 64'(result), 64'(e.r));
      check_output("latency", 64'(lat), 64'(e.lat));
    end
    check_accesses();
    @(negedge clk);
    check_output("busy after op", 64'(busy), 64'd0);
    check_output("done after op", 64'(done), 64'd0);
    check_output("err after op", 64'(err), 64'd0);
  endtask

  initial begin
    int found;
    int pulses;
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int found;
    int pulses;

    // Reset values
    #2 rest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset done", 64'(done), 64'd0);
    check_output("reset err", 64'(err), 64'd0);
    check_output("reset wb_en", 64'(wb_en), 64'd0);
    check_output("reset mem_req", 64'(mem_req), 64'd0);
    check_output("reset mem_we", 64'(mem_we), 64'd0);
    check_output("reset result", 64'(result), 64'd0);
    check_output("reset mem_addr", 64'(mem_addr), 64'd0);
    check_output("reset mem_wdata", 64'(mem_wdata), 64'd0);
    rest = 1'b1;

    preload(8'h10, 32'h0000_0040);
    preload(8'h40, 32'h0000_DEAD);
    preload(8'h20, 32'h0000_0080);
    preload(8'h30, 32'hFFFF_FFFF);

    // Ack with no request outstanding must not start anything
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    check_output("stray ack busy", 64'(busy), 64'd0);
    check_output("stray ack done", 64'(done), 64'd0);
    check_output("stray ack mem_req", 64'(mem_req), 64'd0);
    stray_ack = 1'b0;

    // op_code 3 is not an op
    apply_stimulus(2'd3, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    check_output("op3 busy", 64'(busy), 64'd0);
    check_output("op3 mem_req", 64'(mem_req), 64'd0);

    // LWi: 0x10 -> 0x40 -> 0xDEAD
    expect_op(1'b1, 1'b0, 1'b1, 32'h0000_DEAD, 5);
    expect_acc(1'b0, 32'h10, 32'h40);
    expect_acc(1'b0, 32'h40, 32'hDEAD);
    apply_stimulus(2'd2, 32'h10, 32'h0);
    run_and_check(40, 1);
    check_output("LWi busy cycles", 64'(last_busy), 64'd5);

    // SWi: ptr at 0x20 is 0x80, store 0x1234 there
    expect_op(1'b1, 1'b0, 1'b0, 32'h0000_0080, 5);
    expect_acc(1'b0, 32'h20, 32'h80);
    expect_acc(1'b1, 32'h80, 32'h1234);
    apply_stimulus(2'd1, 32'h20, 32'h1234);
    run_and_check(40, 1);

    // Add with wrap-around: 0xFFFFFFFF + 2 = 1
    expect_op(1'b1, 1'b0, 1'b0, 32'h0000_0001, 5);
    expect_acc(1'b0, 32'h30, 32'hFFFF_FFFF);
    expect_acc(1'b1, 32'h30, 32'h0000_0001);
    apply_stimulus(2'd0, 32'h30, 32'h2);
    run_and_check(40, 1);

    // LWi with three wait states on every access
    wait_cfg = 8'd3;
    expect_op(1'b1, 1'b0, 1'b1, 32'h0000_DEAD, 11);
    expect_acc(1'b0, 32'h10, 32'h40);
    expect_acc(1'b0, 32'h40, 32'hDEAD);
    apply_stimulus(2'd2, 32'h10, 32'h0);
    run_and_check(60, 1);
    check_output("wait LWi busy cycles", 64'(last_busy), 64'd11);
    wait_cfg = 8'd0;

    // Start while busy is dropped, not queued
    expect_op(1'b1, 1'b0, 1'b1, 32'h0000_DEAD, 5);
    expect_acc(1'b0, 32'h10, 32'h40);
    expect_acc(1'b0, 32'h40, 32'hDEAD);
    apply_stimulus(2'd2, 32'h10, 32'h0);
    apply_stimulus(2'd1, 32'h20, 32'h5555);
    run_and_check(40, 2);
    repeat (3) @(negedge clk);
    check_output("no queued op busy", 64'(busy), 64'd0);
    check_output("no queued op mem_req", 64'(mem_req), 64'd0);

    // Timeout: memory never answers
    ack_enable = 1'b0;
    expect_op(1'b0, 1'b1, 1'b0, 32'h0000_DEAD, 10);
    apply_stimulus(2'd2, 32'h10, 32'h0);
    run_and_check(40, 1);
    check_output("timeout mem_req at err", 64'(last_req), 64'd0);
    ack_enable = 1'b1;

    // Async reset in the middle of the SWi write access
    wait_cfg = 8'd3;
    expect_acc(1'b0, 32'h20, 32'h80);
    apply_stimulus(2'd1, 32'h20, 32'h9999);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (mem_req && mem_we) found = 1;
      else @(negedge clk);
    end
    check_output("reached WR", 64'(found), 64'd1);
    rest = 1'b0;
    #1;
    check_output("abort busy", 64'(busy), 64'd0);
    check_output("abort mem_req", 64'(mem_req), 64'd0);
    check_output("abort mem_we", 64'(mem_we), 64'd0);
    check_output("abort done", 64'(done), 64'd0);
    check_output("abort err", 64'(err), 64'd0);
    check_output("abort wb_en", 64'(wb_en), 64'd0);
    check_output("abort result", 64'(result), 64'd0);
    check_output("abort mem_addr", 64'(mem_addr), 64'd0);
    check_output("abort mem_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rest     = 1'b1;
    wait_cfg = 8'd0;
    pulses   = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || err || busy) pulses++;
    end
    check_output("no activity after abort", 64'(pulses), 64'd0);
    check_accesses();
    check_output("aborted write kept old data", 64'(mem[8'h80]), 64'h1234);

    // Whole-run protocol properties
    check_output("req fields stable", 64'(stab_err), 64'd0);
    check_output("gap after ack", 64'(gap_err), 64'd0);
    check_output("done and err together", 64'(both_cnt), 64'd0);
    check_output("pending completions", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
